mips16_multicycle_ctrl: RTL and testbench

- Multicycle main control FSM for the mips16 core. Sequences fetch, decode, execute, memory and writeback over a shared ALU, a single unified memory port and the register file.
- Drives the 3-bit ALUOp consumed by alu_control, plus all datapath mux selects and write enables.
- Handles variable-latency memory through a req/ready handshake.

---
 rtl/mips16_pkg.sv | 82 ++++++++
 rtl/mips16_mem_wait.sv | 33 +++
 rtl/mips16_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_mips16_multicycle_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared encodings for the mips16 multicycle control path: opcodes, ALUOp,
// FSM states and the datapath mux select codes.
package mips16_pkg;

  // Instruction opcodes (IR[15:12])
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ANDI = 4'b0010;
  localparam logic [3:0] OP_ORI  = 4'b0011;
  localparam logic [3:0] OP_SLTI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_BNE  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;
  localparam logic [3:0] OP_JAL  = 4'b1010;
  localparam logic [3:0] OP_LI   = 4'b1011;

  // R-type function code that turns the instruction into jr
  localparam logic [5:0] FUNC_JR = 6'b001000;

  // ALUOp encodings understood by alu_control
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b110;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  // Register file write-address select
  localparam logic [1:0] REG_DST_RT   = 2'b00;
  localparam logic [1:0] REG_DST_RD   = 2'b01;
  localparam logic [1:0] REG_DST_LINK = 2'b10;

  // Register file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_IMM    = 2'b11;

  // ALU B operand select
  localparam logic [1:0] ALU_B_RT    = 2'b00;
  localparam logic [1:0] ALU_B_TWO   = 2'b01;
  localparam logic [1:0] ALU_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_B_SHIFT = 2'b11;

  // Main control states
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    R_WB     = 4'd3,
    EXEC_I   = 4'd4,
    I_WB     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    LW_WB    = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JR       = 4'd12,
    LI_WB    = 4'd13,
    TRAP     = 4'd14
  } state_t;

  // ALU operation for the immediate-format arithmetic/logic instructions
  function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips16_mem_wait.sv
// Memory wait-state counter. Counts consecutive cycles an access is held
// without mem_ready and flags a timeout; TIMEOUT=0 disables the check.
module mips16_mem_wait #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic timeout
);

  localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] count;

  // Count wait cycles; any cycle without a pending wait restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!req || ready) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end
  end

  // Fires in the wait cycle that brings the count to TIMEOUT
  assign timeout = (TIMEOUT > 0) && req && !ready && (count == LAST);

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multicycle main control FSM for the mips16 core: sequences fetch, decode,
// execute, memory and writeback and drives all datapath selects/enables.
module mips16_multicycle_ctrl
  import mips16_pkg::*;
#(
  parameter logic [2:0]  REG_LINK    = 3'd7,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       illegal_instr,
  output logic       mem_err,
  output logic [3:0] state_o
);

  state_t state, state_next;
  logic   illegal_reg, mem_err_reg;
  logic   access, wait_timeout;

  // The link register index is applied by the datapath's write-address mux
  // when reg_dst selects REG_LINK; kept here so both share one parameter set.
  logic unused_reg_link;
  assign unused_reg_link = ^REG_LINK;

  // States that hold the memory port; derived from state alone
  assign access = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

  mips16_mem_wait #(
    .TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (access),
    .ready  (mem_ready),
    .timeout(wait_timeout)
  );

  // State register and sticky fault flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      illegal_reg <= 1'b0;
      mem_err_reg <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE && state_next == TRAP) illegal_reg <= 1'b1;
      if (wait_timeout) mem_err_reg <= 1'b1;
    end
  end

  // Next-state and output decode; outputs forced low while reset is held
  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = PC_SRC_ALU;
    ir_write      = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_RT;
    alu_op        = ALU_ADD;

    case (state)
      FETCH: begin
        if (wait_timeout)   state_next = TRAP;
        else if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        case (opcode)
          OP_R:                            state_next = (func == FUNC_JR) ? JR : EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = EXEC_I;
          OP_LW, OP_SW:                    state_next = MEM_ADDR;
          OP_BEQ, OP_BNE:                  state_next = BRANCH;
          OP_J, OP_JAL:                    state_next = JUMP;
          OP_LI:                           state_next = LI_WB;
          default:                         state_next = TRAP;
        endcase
      end
      EXEC_R:   state_next = R_WB;
      EXEC_I:   state_next = I_WB;
      MEM_ADDR: state_next = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (wait_timeout)   state_next = TRAP;
        else if (mem_ready) state_next = LW_WB;
      end
      MEM_WR: begin
        if (wait_timeout)   state_next = TRAP;
        else if (mem_ready) state_next = FETCH;
      end
      R_WB, I_WB, LW_WB, BRANCH, JUMP, JR, LI_WB: state_next = FETCH;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase

    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = ALU_B_TWO;
          // IR load and PC+2 commit only in the cycle memory delivers
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          // Branch target precomputed into ALUOut
          alu_src_b = ALU_B_SHIFT;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = ALU_B_RT;
          alu_op    = ALU_RTYPE;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = REG_DST_RD;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = ALU_B_IMM;
          alu_op    = imm_alu_op(opcode);
        end
        I_WB: begin
          reg_write = 1'b1;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALU_B_IMM;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        LW_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = ALU_B_RT;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = PC_SRC_ALUOUT;
          branch_ne     = (opcode == OP_BNE);
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          // jal links the old PC+2 in the same cycle the PC is replaced
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_LINK;
            mem_to_reg = M2R_PC;
          end
        end
        JR: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_RS;
        end
        LI_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_IMM;
        end
        default: ;
      endcase
    end
  end

  assign illegal_instr = illegal_reg;
  assign mem_err       = mem_err_reg;
  assign state_o       = state;

endmodule

// File: tb/tb_mips16_multicycle_ctrl.sv
// Directed bench for mips16_multicycle_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_mips16_multicycle_ctrl;
  import mips16_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, rst_n_t;
  logic [3:0] opcode;
  logic [5:0] func;
  logic       mem_ready, mem_ready_t;

  logic       pc_write, pc_write_cond, branch_ne, ir_write, mem_req, mem_we, i_or_d;
  logic       reg_write, alu_src_a, illegal_instr, mem_err;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  logic       pc_write_t, pc_write_cond_t, branch_ne_t, ir_write_t, mem_req_t, mem_we_t, i_or_d_t;
  logic       reg_write_t, alu_src_a_t, illegal_instr_t, mem_err_t;
  logic [1:0] pc_src_t, reg_dst_t, mem_to_reg_t, alu_src_b_t;
  logic [2:0] alu_op_t;
  logic [3:0] state_o_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mips16_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_instr(illegal_instr), .mem_err(mem_err), .state_o(state_o)
  );

  mips16_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n_t), .opcode(opcode), .func(func), .mem_ready(mem_ready_t),
    .pc_write(pc_write_t), .pc_write_cond(pc_write_cond_t), .branch_ne(branch_ne_t),
    .pc_src(pc_src_t), .ir_write(ir_write_t), .mem_req(mem_req_t), .mem_we(mem_we_t),
    .i_or_d(i_or_d_t), .reg_write(reg_write_t), .reg_dst(reg_dst_t), .mem_to_reg(mem_to_reg_t),
    .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t), .alu_op(alu_op_t),
    .illegal_instr(illegal_instr_t), .mem_err(mem_err_t), .state_o(state_o_t)
  );

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH with memory ready, then DECODE; leaves the FSM entering the execute state
  task automatic fetch_decode(input string nm);
    mem_ready = 1'b1;
    #1;
    check({nm, "_fetch_state"}, int'(state_o), int'(FETCH));
    check({nm, "_fetch_ir_write"}, int'(ir_write), 1);
    check({nm, "_fetch_pc_write"}, int'(pc_write), 1);
    check({nm, "_fetch_pc_src"}, int'(pc_src), 0);
    check({nm, "_fetch_mem_req"}, int'(mem_req), 1);
    check({nm, "_fetch_i_or_d"}, int'(i_or_d), 0);
    check({nm, "_fetch_alu_b"}, int'(alu_src_b), 1);
    check({nm, "_fetch_reg_write"}, int'(reg_write), 0);
    tick();
    check({nm, "_dec_state"}, int'(state_o), int'(DECODE));
    check({nm, "_dec_alu_b"}, int'(alu_src_b), 3);
    check({nm, "_dec_alu_a"}, int'(alu_src_a), 0);
    check({nm, "_dec_alu_op"}, int'(alu_op), 0);
    check({nm, "_dec_mem_req"}, int'(mem_req), 0);
    check({nm, "_dec_reg_write"}, int'(reg_write), 0);
    tick();
  endtask

  logic [3:0] imm_op [4];
  int         imm_alu [4];
  logic [3:0] br_op [2];
  int         br_ne [2];
  int         br_zero [2];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    imm_op  = '{OP_SLTI, OP_ANDI, OP_ORI, OP_ADDI};
    imm_alu = '{5, 2, 3, 0};
    br_op   = '{OP_BNE, OP_BEQ};
    br_ne   = '{1, 0};
    br_zero = '{0, 1};

    rst_n = 1'b0; rst_n_t = 1'b0; mem_ready = 1'b0; mem_ready_t = 1'b0;
    opcode = OP_R; func = 6'b100000;
    tick();

    // Reset state
    check("rst_state", int'(state_o), int'(FETCH));
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_alu_b", int'(alu_src_b), 0);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_flags", int'({illegal_instr, mem_err}), 0);

    // FETCH waiting on memory, then reset mid-access
    rst_n = 1'b1; #1;
    check("fwait_mem_req", int'(mem_req), 1);
    check("fwait_ir_write", int'(ir_write), 0);
    check("fwait_pc_write", int'(pc_write), 0);
    tick();
    check("fwait_hold", int'(state_o), int'(FETCH));
    rst_n = 1'b0; #1;
    check("midrst_mem_req", int'(mem_req), 0);
    check("midrst_alu_b", int'(alu_src_b), 0);
    tick();
    rst_n = 1'b1;

    // R-type add
    opcode = OP_R; func = 6'b100000;
    fetch_decode("add");
    check("add_exec_state", int'(state_o), int'(EXEC_R));
    check("add_exec_alu_op", int'(alu_op), 6);
    check("add_exec_alu_a", int'(alu_src_a), 1);
    check("add_exec_alu_b", int'(alu_src_b), 0);
    check("add_exec_reg_write", int'(reg_write), 0);
    tick();
    check("add_wb_state", int'(state_o), int'(R_WB));
    check("add_wb_reg_write", int'(reg_write), 1);
    check("add_wb_reg_dst", int'(reg_dst), 1);
    check("add_wb_m2r", int'(mem_to_reg), 0);
    tick();
    $display("instr add   done, miscompares so far %0d", err_cnt);

    // lw with 3 wait states: 8 cycles total
    opcode = OP_LW;
    fetch_decode("lw");
    mem_ready = 1'b0; #1;
    check("lw_addr_state", int'(state_o), int'(MEM_ADDR));
    check("lw_addr_alu_b", int'(alu_src_b), 2);
    check("lw_addr_alu_a", int'(alu_src_a), 1);
    tick();
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3); #1;
      check("lw_rd_state", int'(state_o), int'(MEM_RD));
      check("lw_rd_mem_req", int'(mem_req), 1);
      check("lw_rd_i_or_d", int'(i_or_d), 1);
      check("lw_rd_mem_we", int'(mem_we), 0);
      tick();
    end
    check("lw_wb_state", int'(state_o), int'(LW_WB));
    check("lw_wb_reg_write", int'(reg_write), 1);
    check("lw_wb_m2r", int'(mem_to_reg), 1);
    check("lw_wb_reg_dst", int'(reg_dst), 0);
    check("lw_wb_mem_req", int'(mem_req), 0);
    tick();
    $display("instr lw    done, miscompares so far %0d", err_cnt);

    // sw: 4 cycles
    opcode = OP_SW;
    fetch_decode("sw");
    check("sw_addr_state", int'(state_o), int'(MEM_ADDR));
    tick();
    check("sw_wr_state", int'(state_o), int'(MEM_WR));
    check("sw_wr_mem_req", int'(mem_req), 1);
    check("sw_wr_mem_we", int'(mem_we), 1);
    check("sw_wr_i_or_d", int'(i_or_d), 1);
    check("sw_wr_reg_write", int'(reg_write), 0);
    tick();
    $display("instr sw    done, miscompares so far %0d", err_cnt);

    // bne then beq against a zero-flag model
    for (int b = 0; b < 2; b++) begin
      opcode = br_op[b];
      fetch_decode("br");
      check("br_state", int'(state_o), int'(BRANCH));
      check("br_pc_write_cond", int'(pc_write_cond), 1);
      check("br_alu_op", int'(alu_op), 1);
      check("br_pc_src", int'(pc_src), 1);
      check("br_pc_write", int'(pc_write), 0);
      check("br_branch_ne", int'(branch_ne), br_ne[b]);
      check("br_taken", int'(pc_write | (pc_write_cond & (br_zero[b][0] ^ branch_ne))), 1);
      check("br_not_taken", int'(pc_write | (pc_write_cond & (~br_zero[b][0] ^ branch_ne))), 0);
      tick();
      $display("instr %s   done, miscompares so far %0d", (b == 0) ? "bne" : "beq", err_cnt);
    end

    // Immediate ops back to back
    for (int k = 0; k < 4; k++) begin
      opcode = imm_op[k];
      fetch_decode("imm");
      check("imm_exec_state", int'(state_o), int'(EXEC_I));
      check("imm_exec_alu_op", int'(alu_op), imm_alu[k]);
      check("imm_exec_alu_a", int'(alu_src_a), 1);
      check("imm_exec_alu_b", int'(alu_src_b), 2);
      tick();
      check("imm_wb_state", int'(state_o), int'(I_WB));
      check("imm_wb_reg_write", int'(reg_write), 1);
      check("imm_wb_reg_dst", int'(reg_dst), 0);
      check("imm_wb_m2r", int'(mem_to_reg), 0);
      tick();
      $display("instr imm op=%b done, miscompares so far %0d", imm_op[k], err_cnt);
    end

    // li: 3 cycles
    opcode = OP_LI;
    fetch_decode("li");
    check("li_state", int'(state_o), int'(LI_WB));
    check("li_reg_write", int'(reg_write), 1);
    check("li_m2r", int'(mem_to_reg), 3);
    check("li_reg_dst", int'(reg_dst), 0);
    tick();
    $display("instr li    done, miscompares so far %0d", err_cnt);

    // jal
    opcode = OP_JAL;
    fetch_decode("jal");
    check("jal_state", int'(state_o), int'(JUMP));
    check("jal_pc_write", int'(pc_write), 1);
    check("jal_pc_src", int'(pc_src), 2);
    check("jal_reg_write", int'(reg_write), 1);
    check("jal_reg_dst", int'(reg_dst), 2);
    check("jal_m2r", int'(mem_to_reg), 2);
    tick();
    $display("instr jal   done, miscompares so far %0d", err_cnt);

    // j: no link write
    opcode = OP_J;
    fetch_decode("j");
    check("j_state", int'(state_o), int'(JUMP));
    check("j_pc_write", int'(pc_write), 1);
    check("j_reg_write", int'(reg_write), 0);
    tick();
    $display("instr j     done, miscompares so far %0d", err_cnt);

    // jr
    opcode = OP_R; func = 6'b001000;
    fetch_decode("jr");
    check("jr_state", int'(state_o), int'(JR));
    check("jr_pc_src", int'(pc_src), 3);
    check("jr_pc_write", int'(pc_write), 1);
    check("jr_reg_write", int'(reg_write), 0);
    tick();
    #1;
    check("jr_back_fetch", int'(state_o), int'(FETCH));
    check("jr_after_reg_write", int'(reg_write), 0);
    $display("instr jr    done, miscompares so far %0d", err_cnt);

    // Illegal opcode: TRAP held for 20 cycles, stray mem_ready ignored
    opcode = 4'b1110; func = 6'b000000;
    fetch_decode("ill");
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      check("trap_state", int'(state_o), int'(TRAP));
      check("trap_illegal", int'(illegal_instr), 1);
      check("trap_enables", int'({mem_req, pc_write, reg_write, ir_write, pc_write_cond}), 0);
      tick();
    end
    rst_n = 1'b0; #1;
    check("trap_rst_illegal", int'(illegal_instr), 0);
    check("trap_rst_state", int'(state_o), int'(FETCH));
    tick();
    rst_n = 1'b1;
    $display("instr ill   done, miscompares so far %0d", err_cnt);

    // Timeout instance: mem_ready stuck low in FETCH
    rst_n_t = 1'b1; mem_ready_t = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check("to_wait_state", int'(state_o_t), int'(FETCH));
      check("to_wait_mem_req", int'(mem_req_t), 1);
      check("to_wait_mem_err", int'(mem_err_t), 0);
      tick();
    end
    #1;
    check("to_c5_state", int'(state_o_t), int'(TRAP));
    check("to_c5_mem_err", int'(mem_err_t), 1);
    check("to_c5_mem_req", int'(mem_req_t), 0);
    tick();
    tick();
    check("to_sticky_mem_err", int'(mem_err_t), 1);
    check("to_no_illegal", int'(illegal_instr_t), 0);
    $display("timeout run done, miscompares so far %0d", err_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
